antilog_module: RTL and testbench

Iterative base-2 antilog (exp2) converter for the MFCC feature path. It is the inverse of the log stage: it takes a signed Q11 log2-domain value and returns the unsigned linear-domain magnitude in fixed point. It is used for reconstruction, debug readback and the dB-floor/threshold comparison path. Each transaction is a ready/valid handshake on both sides, and latency is fixed per sample.

---
 rtl/antilog_module_pkg.sv | 23 ++
 rtl/antilog_module_if.sv | 17 +
 rtl/antilog_module_const_rom.sv | 11 +
 rtl/antilog_module.sv | 111 +++++++++++
 tb/tb_antilog_module.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/antilog_module_pkg.sv
// Shared types and constants for the iterative base-2 antilog converter.
package antilog_module_pkg;

   localparam int unsigned LOG_W     = 16;
   localparam int unsigned LIN_W     = 32;
   localparam int unsigned Q_L_DEF   = 11;
   localparam int unsigned Q_OUT_DEF = 15;
   localparam int unsigned MANT_FRAC = 30;

   localparam logic [31:0] MANT_ONE   = 32'h4000_0000;
   localparam logic [63:0] ROUND_HALF = 64'd1 << (MANT_FRAC - 1);

   typedef enum logic [1:0] {IDLE, ITER, SCALE, OUT} state_t;

   // C[k] = round(2^(2^-(k+1)) * 2^30), k = 0..15
   localparam logic [31:0] C_TAB [16] = '{
      32'd1518500250, 32'd1276901417, 32'd1170923762, 32'd1121280436,
      32'd1097253708, 32'd1085434106, 32'd1079572136, 32'd1076653033,
      32'd1075196443, 32'd1074468888, 32'd1074105294, 32'd1073923544,
      32'd1073832680, 32'd1073787251, 32'd1073764537, 32'd1073753181
   };

endpackage

// File: rtl/antilog_module_if.sv
// Input (log domain) and output (linear domain) ready/valid channels.
interface antilog_module_if;
   import antilog_module_pkg::*;

   logic [LOG_W-1:0] log_in;
   logic             log_valid;
   logic             log_ready;
   logic [LIN_W-1:0] lin_out;
   logic             lin_valid;
   logic             lin_ready;
   logic             lin_sat;

   modport master (output log_in, log_valid, lin_ready,
                   input  log_ready, lin_out, lin_valid, lin_sat);
   modport slave  (input  log_in, log_valid, lin_ready,
                   output log_ready, lin_out, lin_valid, lin_sat);
endinterface

// File: rtl/antilog_module_const_rom.sv
// Combinational lookup of the per-step Q30 multiplier C[k].
module antilog_const_rom
   import antilog_module_pkg::*;
(
   input  logic [3:0]  idx,
   output logic [31:0] coef_c
);

   assign coef_c = C_TAB[idx];

endmodule

// File: rtl/antilog_module.sv
// Iterative exp2: one fractional bit per cycle, then a binary-point shift
// by the integer part with saturation/underflow handling.
module antilog_module
   import antilog_module_pkg::*;
#(
   parameter int unsigned Q_L   = Q_L_DEF,
   parameter int unsigned Q_OUT = Q_OUT_DEF
) (
   input logic             clk,
   input logic             rst,
   antilog_module_if.slave bus
);

   localparam logic [15:0] FP_MASK = 16'((32'd1 << Q_L) - 32'd1);
   localparam int          S_OFF   = int'(MANT_FRAC) - int'(Q_OUT);

   state_t             state;
   logic signed [15:0] ip;
   logic [15:0]        fp;
   logic [31:0]        mant;
   logic [3:0]         k;
   logic [31:0]        lin_out_q;
   logic               lin_valid_q;
   logic               lin_sat_q;

   logic [31:0] coef_c;
   logic [63:0] prod_c;
   logic [31:0] mant_mul_c;
   int          s_c;
   logic [63:0] wide_c;
   logic [31:0] scale_out_c;
   logic        scale_sat_c;

   antilog_const_rom u_rom (
      .idx    (k),
      .coef_c (coef_c)
   );

   // Q30 x Q30 product, rounded half-up back to Q30
   assign prod_c     = 64'(mant) * 64'(coef_c) + ROUND_HALF;
   assign mant_mul_c = 32'(prod_c >> MANT_FRAC);

   // Move the binary point from Q30 to Q_OUT and apply 2^ip
   always_comb begin
      s_c         = int'(ip) - S_OFF;
      wide_c      = '0;
      scale_out_c = '0;
      scale_sat_c = 1'b0;
      if (s_c >= 32) begin
         scale_sat_c = 1'b1;
      end else if (s_c >= 0) begin
         wide_c = 64'(mant) << 6'(s_c);
         if (|wide_c[63:32]) scale_sat_c = 1'b1;
         else                scale_out_c = wide_c[31:0];
      end else if (s_c > -32) begin
         scale_out_c = mant >> 5'(-s_c);
      end
      if (scale_sat_c) scale_out_c = 32'hFFFF_FFFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ip          <= '0;
         fp          <= '0;
         mant        <= MANT_ONE;
         k           <= '0;
         lin_out_q   <= '0;
         lin_valid_q <= 1'b0;
         lin_sat_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.log_valid) begin
                  ip    <= $signed(bus.log_in) >>> Q_L;
                  fp    <= bus.log_in & FP_MASK;
                  mant  <= MANT_ONE;
                  k     <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               // fp is shifted left so the bit for step k is always at Q_L-1
               if (fp[Q_L-1]) mant <= mant_mul_c;
               fp <= fp << 1;
               k  <= k + 4'd1;
               if (k == 4'(Q_L - 1)) state <= SCALE;
            end
            SCALE: begin
               lin_out_q   <= scale_out_c;
               lin_sat_q   <= scale_sat_c;
               lin_valid_q <= 1'b1;
               state       <= OUT;
            end
            OUT: begin
               if (bus.lin_ready) begin
                  lin_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.log_ready = (state == IDLE) & ~rst;
   assign bus.lin_out   = lin_out_q;
   assign bus.lin_valid = lin_valid_q;
   assign bus.lin_sat   = lin_sat_q;

endmodule

// File: tb/tb_antilog_module.sv
// Directed bench for antilog_module: default build plus a Q_OUT=18 build for saturation.
module tb_antilog_module;

   typedef struct {
      string       tag;
      logic [31:0] val;
      logic [31:0] tol;
      logic        sat;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];

   antilog_module_if b ();
   antilog_module_if b18 ();

   antilog_module dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   antilog_module #(.Q_OUT(18)) dut18 (
      .clk (clk),
      .rst (rst),
      .bus (b18)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_range(input string tag, input logic [63:0] obs,
                              input logic [63:0] lo, input logic [63:0] hi);
      logic ok;
      ok = (obs >= lo) && (obs <= hi);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? b18.log_ready : b.log_ready;
   endfunction
   function automatic logic vld(input bit sel);
      return sel ? b18.lin_valid : b.lin_valid;
   endfunction
   function automatic logic [31:0] dout(input bit sel);
      return sel ? b18.lin_out : b.lin_out;
   endfunction
   function automatic logic dsat(input bit sel);
      return sel ? b18.lin_sat : b.lin_sat;
   endfunction

   task automatic set_in(input bit sel, input logic [15:0] x, input logic v);
      if (sel) begin b18.log_in = x; b18.log_valid = v; end
      else     begin b.log_in   = x; b.log_valid   = v; end
   endtask

   task automatic set_rdy(input bit sel, input logic r);
      if (sel) b18.lin_ready = r;
      else     b.lin_ready   = r;
   endtask

   // Present x until accepted; returns at #1 after the accept edge.
   task automatic accept(input bit sel, input logic [15:0] x, input bit push,
                         input string tag, input logic [31:0] e,
                         input logic [31:0] tol, input logic es);
      int n;
      if (push) sb.push_back('{tag, e, tol, es});
      set_in(sel, x, 1'b1);
      n = 0;
      while (!rdy(sel) && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 64) check({tag, "_accept_timeout"}, 64'(n), 64'(0));
      @(posedge clk); #1;
      set_in(sel, 16'h0000, 1'b0);
   endtask

   // Wait for lin_valid, then pop the scoreboard and compare.
   task automatic collect(input bit sel, input int lat_exp);
      int   n;
      exp_t e;
      n = 0;
      while (!vld(sel) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'(sb.size()), 64'(1));
         return;
      end
      e = sb.pop_front();
      check({e.tag, "_latency"}, 64'(n), 64'(lat_exp));
      if (e.tol == 0) check({e.tag, "_data"}, 64'(dout(sel)), 64'(e.val));
      else check_range({e.tag, "_data"}, 64'(dout(sel)),
                       64'(e.val) - 64'(e.tol), 64'(e.val) + 64'(e.tol));
      check({e.tag, "_sat"}, 64'(dsat(sel)), 64'(e.sat));
   endtask

   // One consume edge with lin_ready high; block must be back in IDLE.
   task automatic consume(input bit sel, input string tag);
      set_rdy(sel, 1'b1);
      @(posedge clk); #1;
      check({tag, "_consumed"}, 64'(vld(sel)), 64'(0));
      check({tag, "_idle_ready"}, 64'(rdy(sel)), 64'(1));
   endtask

   task automatic txn(input bit sel, input logic [15:0] x, input string tag,
                      input logic [31:0] e, input logic [31:0] tol, input logic es);
      set_rdy(sel, 1'b1);
      accept(sel, x, 1'b1, tag, e, tol, es);
      collect(sel, 12);
      consume(sel, tag);
   endtask

   initial begin
      logic [31:0] held;
      clk    = 1'b0;
      rst    = 1'b1;
      checks = 0;
      errors = 0;
      set_in(1'b0, 16'h0000, 1'b0);
      set_in(1'b1, 16'h0000, 1'b0);
      set_rdy(1'b0, 1'b0);
      set_rdy(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_lin_out", 64'(b.lin_out), 64'(0));
      check("rst_lin_valid", 64'(b.lin_valid), 64'(0));
      check("rst_lin_sat", 64'(b.lin_sat), 64'(0));
      check("rst_log_ready", 64'(b.log_ready), 64'(0));
      check("rst_log_ready_q18", 64'(b18.log_ready), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Default Q_L=11, Q_OUT=15
      txn(1'b0, 16'h0000, "zero", 32'd32768, 32'd0, 1'b0);
      txn(1'b0, 16'h0800, "one", 32'd65536, 32'd0, 1'b0);
      txn(1'b0, 16'h0400, "half", 32'd46341, 32'd1, 1'b0);
      txn(1'b0, 16'hFC00, "neg_half", 32'd23170, 32'd1, 1'b0);
      txn(1'b0, 16'h8000, "underflow", 32'd0, 32'd0, 1'b0);
      txn(1'b0, 16'h7FFF, "max", 32'd2146756954, 32'd16384, 1'b0);

      // Backpressure: result held for 20 cycles while a new sample waits
      set_rdy(1'b0, 1'b0);
      accept(1'b0, 16'h0800, 1'b1, "bp_first", 32'd65536, 32'd0, 1'b0);
      collect(1'b0, 12);
      held = b.lin_out;
      sb.push_back('{"bp_second", 32'd46341, 32'd1, 1'b0});
      set_in(1'b0, 16'h0400, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("bp_stable", 64'(b.lin_out), 64'(held));
         check("bp_valid_held", 64'(b.lin_valid), 64'(1));
         check("bp_no_accept", 64'(b.log_ready), 64'(0));
      end
      consume(1'b0, "bp_release");
      @(posedge clk); #1;
      set_in(1'b0, 16'h0000, 1'b0);
      collect(1'b0, 12);
      consume(1'b0, "bp_second");

      // Q_OUT=18: saturation boundary at s=2
      txn(1'b1, 16'h7800, "q18_sat15", 32'hFFFF_FFFF, 32'd0, 1'b1);
      txn(1'b1, 16'h7000, "q18_sat14", 32'hFFFF_FFFF, 32'd0, 1'b1);
      txn(1'b1, 16'h6800, "q18_fit13", 32'h8000_0000, 32'd0, 1'b0);
      txn(1'b1, 16'h6000, "q18_fit12", 32'h4000_0000, 32'd0, 1'b0);
      txn(1'b1, 16'h0000, "q18_zero", 32'd262144, 32'd0, 1'b0);

      // Reset during ITER aborts the sample
      set_rdy(1'b0, 1'b1);
      accept(1'b0, 16'h0C00, 1'b0, "abort", 32'd0, 32'd0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_lin_out", 64'(b.lin_out), 64'(0));
      check("abort_lin_valid", 64'(b.lin_valid), 64'(0));
      check("abort_lin_sat", 64'(b.lin_sat), 64'(0));
      check("abort_log_ready", 64'(b.log_ready), 64'(0));
      check("abort_q18_lin_out", 64'(b18.lin_out), 64'(0));
      rst = 1'b0;
      #1;
      check("abort_ready_after", 64'(b.log_ready), 64'(1));
      @(posedge clk); #1;
      txn(1'b0, 16'h0000, "post_reset", 32'd32768, 32'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
